ntt_layer_scheduler: RTL and testbench
======================================

Name: ntt_layer_scheduler

Overview:
Sequencer that drives one Butterfly_unit through a full 256-point Kyber NTT or inverse NTT held in a dual-port coefficient RAM. Per layer it issues one butterfly per cycle: read addresses, twiddle (zeta) ROM index, butterfly valid and the inverse flag. It delays the addresses to form write-back strobes. Between layers it drains the memory and butterfly pipeline so that no read-after-write hazard can occur. It sits between the top-level NTT controller (start/done handshake) and the RAM, zeta ROM and butterfly datapath.

Parameters:
N, 256, polynomial length; power of two.
LOG_N, 8, log2(N); sets address width.
LAYERS, 7, number of butterfly layers (len runs N/2 down to 2).
MEM_LAT, 1, RAM read latency in cycles.
BF_LAT, 3, butterfly latency from valid_in to U_OUT/V_OUT.

Ports:
clk  in  1  system clock, rising edge
r  in  1  asynchronous, active-low reset (r=0 resets)
start  in  1  single-cycle request, sampled only in IDLE
inverse_req  in  1  0=NTT, 1=iNTT; latched together with start
busy  out  1  high from the cycle after start until the done cycle
done  out  1  one-cycle pulse after the final write-back
rd_en  out  1  RAM read strobe, both ports
rd_a  out  LOG_N  address of the first operand (j)
rd_b  out  LOG_N  address of the second operand (j+len)
zeta_idx  out  LOG_N-1  twiddle ROM index k
bf_valid  out  1  butterfly valid_in; equals rd_en delayed by MEM_LAT
bf_inverse  out  1  latched inverse flag, constant while busy
wr_en  out  1  write-back strobe, U to wr_a and V to wr_b
wr_a  out  LOG_N  U write address
wr_b  out  LOG_N  V write address

Behaviour:
- Reset: FSM=IDLE. All outputs 0. Counters and delay line cleared. Reset asserted mid-operation aborts immediately; done does not pulse.
- FSM states: IDLE -> ISSUE on start. ISSUE -> DRAIN after butterfly count c=N/2-1 is issued. DRAIN -> ISSUE (next layer) once the drain counter reaches D=MEM_LAT+BF_LAT. After the last layer, DRAIN -> DONE. DONE -> IDLE after one cycle; done=1 in DONE only.
- start while busy: ignored. Back-to-back: start in the cycle after DONE is accepted.
- ISSUE, per cycle: c runs 0..N/2-1. Layer l runs 0..LAYERS-1.
- Forward: len=(N/2)>>l. Inverse: len=2<<l.
- Operand indices: g=c>>log2(len), o=c&(len-1). rd_a=2*g*len+o, rd_b=rd_a+len.
- Twiddle index: forward zeta_idx=(1<<l)+g. Inverse zeta_idx=(N/len)-1-g.
- Write-back path: {rd_en,rd_a,rd_b} passes through a D-deep shift register to give {wr_en,wr_a,wr_b}. bf_valid taps this line at stage MEM_LAT.
- DRAIN: rd_en=0. Layer l+1 issues its first read in the cycle after layer l's last wr_en.
- Timing (defaults, D=4, start at cycle 0): layer l reads at cycles 1+132l .. 128+132l. Final wr_en at cycle 924; done at cycle 925.
- bf_inverse: latched at start, held until IDLE. The butterfly pipelines it internally and needs it stable.

Optional Feature:
Macro NTT_SCHED_PERF_EN.
- Defined: adds output cycle_cnt [15:0]. It clears on an accepted start and increments every busy cycle. It holds its value after done until the next start; reset value 0. For the defaults it reads 925 at done.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package ntt_pkg: N, LOG_N, LAYERS, Kyber Q=3329, and state encodings IDLE/ISSUE/DRAIN/DONE.
- One natural sub-module: ntt_wb_delay, a parameterised D-stage valid+address shift register with active-low asynchronous clear.
- The address/zeta generator stays inline in the FSM.

Test Plan:
- Forward start, inverse_req=0: first reads (0,128,k=1), (1,129,k=1) ... (127,255,k=1). First wr_en at cycle 5 with wr_a=0, wr_b=128.
- Forward layer 1: at cycle 133, rd_a=0, rd_b=64, zeta_idx=2. At c=64, rd_a=128, rd_b=192, zeta_idx=3. Layer 6 first read: (0,2,k=64).
- Inverse start: first read (0,2,k=127), next (1,3,k=127), then (4,6,k=126). Last layer reads (0,128,k=1). bf_inverse=1 throughout busy.
- Full run: no rd_en while any wr_en is pending in the previous layer. Exactly 896 rd_en and 896 wr_en. done only at cycle 925. Golden model compares against a reference NTT result.
- start pulsed at cycle 300 while busy: ignored, schedule unchanged. Reset pulled low at cycle 400: all outputs 0 next edge, no done; a new start runs cleanly.
- NTT_SCHED_PERF_EN defined: cycle_cnt=925 at done and holds. Macro undefined: module elaborates without the port.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and schedule helper for the NTT layer scheduler.
package ntt_pkg;

    localparam int unsigned N        = 256;
    localparam int unsigned LOG_N    = 8;
    localparam int unsigned LAYERS   = 7;
    localparam int unsigned MEM_LAT  = 1;
    localparam int unsigned BF_LAT   = 3;
    localparam int unsigned Q        = 3329;

    // Write-back delay: a read issued in cycle t is written back in cycle t+WB_DEPTH.
    localparam int unsigned WB_DEPTH = MEM_LAT + BF_LAT;
    localparam int unsigned LAYER_W  = $clog2(LAYERS);
    localparam int unsigned CNT_W    = LOG_N - 1;
    localparam int unsigned DRN_W    = $clog2(WB_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One entry of the write-back delay line.
    typedef struct packed {
        logic             vld;
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
    } wb_beat_t;

    // Operand addresses and twiddle index of one butterfly.
    typedef struct packed {
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
        logic [LOG_N-2:0] k;
    } bf_sched_t;

    // Butterfly c of layer `layer`; len is N/2>>layer forward, 2<<layer inverse.
    function automatic bf_sched_t bf_sched(input logic [LAYER_W-1:0] layer,
                                           input logic [CNT_W-1:0]   c,
                                           input logic               inv);
        int unsigned      sh;
        logic [LOG_N-1:0] len;
        logic [LOG_N-1:0] cc;
        logic [LOG_N-1:0] g;
        logic [LOG_N-1:0] o;
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] kf;
        bf_sched_t        s;
        sh   = inv ? 32'(layer) + 32'd1 : LOG_N - 32'd1 - 32'(layer);
        len  = LOG_N'(1) << sh;
        cc   = LOG_N'(c);
        g    = cc >> sh;
        o    = cc & (len - LOG_N'(1));
        a    = (g << (sh + 32'd1)) | o;
        kf   = inv ? (LOG_N'(1) << (LOG_N - sh)) - LOG_N'(1) - g
                   : (LOG_N'(1) << layer) + g;
        s.a  = a;
        s.b  = a + len;
        s.k  = (LOG_N-1)'(kf);
        return s;
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// DEPTH-stage valid+address shift register with async active-low clear.
// Ports: clk, rst_n; in_beat (stage input); tap_vld (valid after TAP stages);
//        out_beat (beat after DEPTH stages).
module ntt_wb_delay
    import ntt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAP   = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  wb_beat_t in_beat,
    output logic     tap_vld,
    output wb_beat_t out_beat
);

    wb_beat_t pipe_q [DEPTH];
    wb_beat_t pipe_d [DEPTH];

    // Shift by one stage per cycle.
    always_comb begin
        pipe_d[0] = in_beat;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tap_vld  = pipe_q[TAP-1].vld;
    assign out_beat = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_layer_scheduler.sv
// Sequencer driving one butterfly unit through a 256-point Kyber NTT / iNTT.
// Ports: clk, r (async active-low reset); start/inverse_req from the controller;
//        busy/done handshake; rd_en/rd_a/rd_b RAM reads; zeta_idx twiddle index;
//        bf_valid/bf_inverse butterfly controls; wr_en/wr_a/wr_b write-back.
// Build option: define NTT_SCHED_PERF_EN to add the cycle_cnt[15:0] output.
module ntt_layer_scheduler
    import ntt_pkg::*;
(
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             inverse_req,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_a,
    output logic [LOG_N-1:0] rd_b,
    output logic [LOG_N-2:0] zeta_idx,
    output logic             bf_valid,
    output logic             bf_inverse,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_a,
    output logic [LOG_N-1:0] wr_b
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [15:0]      cycle_cnt
`endif
);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0]   c_q, c_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG_N-1:0]   rd_a_q, rd_a_d;
    logic [LOG_N-1:0]   rd_b_q, rd_b_d;
    logic [LOG_N-2:0]   zeta_q, zeta_d;
    bf_sched_t          sched;
    wb_beat_t           rd_beat;
    wb_beat_t           wr_beat;

    // Next state; outputs are registered from the next-state view so that the
    // first read appears in the cycle right after start is sampled.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        c_d     = c_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    layer_d = '0;
                    c_d     = '0;
                    inv_d   = inverse_req;
                end
            end
            ISSUE: begin
                if (c_q == CNT_W'(N/2 - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    c_d = c_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Last write-back of this layer lands in the final drain cycle.
                if (drain_q == DRN_W'(WB_DEPTH - 1)) begin
                    if (layer_q == LAYER_W'(LAYERS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        layer_d = layer_q + LAYER_W'(1);
                        c_d     = '0;
                    end
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                inv_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sched   = bf_sched(layer_d, c_d, inv_d);
        rd_en_d = (state_d == ISSUE);
        rd_a_d  = rd_en_d ? sched.a : '0;
        rd_b_d  = rd_en_d ? sched.b : '0;
        zeta_d  = rd_en_d ? sched.k : '0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            layer_q <= '0;
            c_q     <= '0;
            drain_q <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            zeta_q  <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            c_q     <= c_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            zeta_q  <= zeta_d;
        end
    end

    // Read beat delayed to the write-back; butterfly valid taps after the RAM latency.
    assign rd_beat = {rd_en_q, rd_a_q, rd_b_q};

    ntt_wb_delay #(
        .DEPTH (WB_DEPTH),
        .TAP   (MEM_LAT)
    ) u_wb_delay (
        .clk      (clk),
        .rst_n    (r),
        .in_beat  (rd_beat),
        .tap_vld  (bf_valid),
        .out_beat (wr_beat)
    );

`ifdef NTT_SCHED_PERF_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    // Counts busy cycles of the current run, holding after done.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == IDLE && start) begin
            cycle_cnt_d = 16'd1;
        end else if (busy_d) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_a       = rd_a_q;
    assign rd_b       = rd_b_q;
    assign zeta_idx   = zeta_q;
    assign bf_inverse = inv_q;
    assign wr_en      = wr_beat.vld;
    assign wr_a       = wr_beat.a;
    assign wr_b       = wr_beat.b;

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Bench for ntt_layer_scheduler: table-driven spot checks plus a scoreboard of
// the full read schedule (from the Kyber reference loops) and delayed write-backs.
module tb_ntt_layer_scheduler;

    localparam int RUN_LEN = 926;
    localparam int WB_D    = 4;

    logic       clk;
    logic       r;
    logic       start;
    logic       inverse_req;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic [6:0] zeta_idx;
    logic       bf_valid;
    logic       bf_inverse;
    logic       wr_en;
    logic [7:0] wr_a;
    logic [7:0] wr_b;
`ifdef NTT_SCHED_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    ntt_layer_scheduler dut (
        .clk         (clk),
        .r           (r),
        .start       (start),
        .inverse_req (inverse_req),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .zeta_idx    (zeta_idx),
        .bf_valid    (bf_valid),
        .bf_inverse  (bf_inverse),
        .wr_en       (wr_en),
        .wr_a        (wr_a),
        .wr_b        (wr_b)
`ifdef NTT_SCHED_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int run; int cyc; bit drv; bit inv;
        bit busy; bit rd; int a; int b; int k;
        bit bfv; bit bfi; bit wr; int wa; int wb; bit done;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] k;
    } rd_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         due;
    } wr_t;

    vec_t vecs[$];
    rd_t  exp_rd[$];
    wr_t  exp_wr[$];

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int t0    = 0;
    int run_id = -1;
    bit run_inv  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit run_full [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int rd_seen, wr_seen, done_seen, done_cyc;
    logic prev_rd;

    always @(posedge clk) edges <= edges + 1;

    function automatic vec_t mk(int run, int cyc, bit drv, bit inv, bit bsy, bit rd,
                                int a, int b, int k, bit bfv, bit bfi, bit wr,
                                int wa, int wb, bit dn);
        vec_t v;
        v.run = run; v.cyc = cyc; v.drv = drv; v.inv = inv;
        v.busy = bsy; v.rd = rd; v.a = a; v.b = b; v.k = k;
        v.bfv = bfv; v.bfi = bfi; v.wr = wr; v.wa = wa; v.wb = wb; v.done = dn;
        return v;
    endfunction

    function void chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0h want %0h", name, $time, got, exp);
        end
    endfunction

    // Reference Kyber loop order: forward k counts up from 1, inverse down from 127.
    function automatic void gen_sched(bit inv);
        rd_t e;
        int  k;
        exp_rd.delete();
        k = inv ? 127 : 1;
        for (int l = 0; l < 7; l++) begin
            int len;
            len = inv ? (2 << l) : (128 >> l);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    e.a = 8'(j);
                    e.b = 8'(j + len);
                    e.k = 7'(k);
                    exp_rd.push_back(e);
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endfunction

    // Per-cycle monitor: every comparison of the bench happens here.
    always @(negedge clk) begin : mon
        int   cur;
        rd_t  er;
        wr_t  ew;
        vec_t v;
        cur = edges - t0;
        if (!r) begin
            chk("reset_outputs",
                {busy, done, rd_en, rd_a, rd_b, zeta_idx, bf_valid, bf_inverse, wr_en, wr_a, wr_b}, 0);
`ifdef NTT_SCHED_PERF_EN
            chk("reset_cycle_cnt", cycle_cnt, 0);
`endif
            exp_wr.delete();
            prev_rd = 1'b0;
        end else begin
            if (run_id >= 0 && cur == 0) begin
                gen_sched(run_inv[run_id]);
                exp_wr.delete();
                rd_seen = 0; wr_seen = 0; done_seen = 0; done_cyc = -1;
            end
            chk("bf_valid", bf_valid, prev_rd);
            // Write-back scoreboard.
            if (wr_en) wr_seen++;
            if (exp_wr.size() > 0 && exp_wr[0].due == edges) begin
                ew = exp_wr.pop_front();
                chk("wr_en_due", wr_en, 1);
                chk("wr_addr", {wr_a, wr_b}, {ew.a, ew.b});
            end else begin
                chk("wr_en_idle", wr_en, 0);
            end
            // Read schedule scoreboard.
            if (rd_en) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_extra", rd_en, 0);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_sched", {rd_a, rd_b, zeta_idx}, er);
                    if (rd_seen % 128 == 0 && rd_seen > 0)
                        chk("layer_hazard_pending_wr", exp_wr.size(), 0);
                    ew.a = rd_a; ew.b = rd_b; ew.due = edges + WB_D;
                    exp_wr.push_back(ew);
                end
                rd_seen++;
            end
            if (done) begin
                done_seen++;
                done_cyc = cur;
            end
            // Spot checks from the vector table.
            foreach (vecs[i]) begin
                if (vecs[i].run == run_id && vecs[i].cyc == cur) begin
                    v = vecs[i];
                    chk($sformatf("ctrl_r%0d_c%0d", run_id, cur),
                        {busy, rd_en, bf_valid, bf_inverse, wr_en, done},
                        {v.busy, v.rd, v.bfv, v.bfi, v.wr, v.done});
                    if (v.rd)
                        chk($sformatf("rd_r%0d_c%0d", run_id, cur),
                            {rd_a, rd_b, zeta_idx}, {8'(v.a), 8'(v.b), 7'(v.k)});
                    if (v.wr)
                        chk($sformatf("wr_r%0d_c%0d", run_id, cur),
                            {wr_a, wr_b}, {8'(v.wa), 8'(v.wb)});
                end
            end
            // End-of-run totals.
            if (run_id >= 0 && cur == RUN_LEN - 1) begin
                if (run_full[run_id]) begin
                    chk("rd_count", rd_seen, 896);
                    chk("wr_count", wr_seen, 896);
                    chk("done_count", done_seen, 1);
                    chk("done_cycle", done_cyc, 925);
                    chk("rd_sched_left", exp_rd.size(), 0);
`ifdef NTT_SCHED_PERF_EN
                    chk("cycle_cnt", cycle_cnt, 925);
`endif
                end else begin
                    chk("abort_done_count", done_seen, 0);
                end
            end
            prev_rd = rd_en;
        end
    end

    initial begin
        r = 1'b1; start = 1'b0; inverse_req = 1'b0;
        rd_seen = 0; wr_seen = 0; done_seen = 0; done_cyc = -1; prev_rd = 1'b0;
        // run, cyc, drv, inv, busy, rd, a, b, k, bfv, bfi, wr, wa, wb, done
        vecs.push_back(mk(0,   0, 1, 0, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0,   1, 0, 0, 1, 1,   0, 128,   1, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0,   2, 0, 0, 1, 1,   1, 129,   1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0,   5, 0, 0, 1, 1,   4, 132,   1, 1, 0, 1,   0, 128, 0));
        vecs.push_back(mk(0, 128, 0, 0, 1, 1, 127, 255,   1, 1, 0, 1, 123, 251, 0));
        vecs.push_back(mk(0, 129, 0, 0, 1, 0,   0,   0,   0, 1, 0, 1, 124, 252, 0));
        vecs.push_back(mk(0, 130, 0, 0, 1, 0,   0,   0,   0, 0, 0, 1, 125, 253, 0));
        vecs.push_back(mk(0, 132, 0, 0, 1, 0,   0,   0,   0, 0, 0, 1, 127, 255, 0));
        vecs.push_back(mk(0, 133, 0, 0, 1, 1,   0,  64,   2, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 197, 0, 0, 1, 1, 128, 192,   3, 1, 0, 1,  60, 124, 0));
        vecs.push_back(mk(0, 300, 1, 1, 1, 1,  67,  99,   5, 1, 0, 1,  31,  63, 0));
        vecs.push_back(mk(0, 302, 0, 0, 1, 1,  69, 101,   5, 1, 0, 1,  65,  97, 0));
        vecs.push_back(mk(0, 793, 0, 0, 1, 1,   0,   2,  64, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 920, 0, 0, 1, 1, 253, 255, 127, 1, 0, 1, 245, 247, 0));
        vecs.push_back(mk(0, 924, 0, 0, 1, 0,   0,   0,   0, 0, 0, 1, 253, 255, 0));
        vecs.push_back(mk(0, 925, 0, 0, 1, 0,   0,   0,   0, 0, 0, 0,   0,   0, 1));
        vecs.push_back(mk(1,   0, 1, 1, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(1,   1, 0, 0, 1, 1,   0,   2, 127, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(1,   2, 0, 0, 1, 1,   1,   3, 127, 1, 1, 0,   0,   0, 0));
        vecs.push_back(mk(1,   3, 0, 0, 1, 1,   4,   6, 126, 1, 1, 0,   0,   0, 0));
        vecs.push_back(mk(1,   5, 0, 0, 1, 1,   8,  10, 125, 1, 1, 1,   0,   2, 0));
        vecs.push_back(mk(1, 793, 0, 0, 1, 1,   0, 128,   1, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(1, 925, 0, 0, 1, 0,   0,   0,   0, 0, 1, 0,   0,   0, 1));
        vecs.push_back(mk(2,   0, 1, 0, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2,   1, 0, 0, 1, 1,   0, 128,   1, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 399, 0, 0, 1, 1,   2,  18,   8, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 402, 0, 0, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 600, 0, 0, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(3,   0, 1, 1, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(3,   1, 0, 0, 1, 1,   0,   2, 127, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(3, 925, 0, 0, 1, 0,   0,   0,   0, 0, 1, 0,   0,   0, 1));

        #2 r = 1'b0;
        repeat (3) @(posedge clk);
        #1 r = 1'b1;
        @(posedge clk);
        #1;
        // Runs follow each other directly: run n+1 starts the cycle after run n's done.
        for (int run = 0; run < 4; run++) begin
            t0     = edges;
            run_id = run;
            for (int c = 0; c < RUN_LEN; c++) begin
                start       = 1'b0;
                inverse_req = 1'b0;
                foreach (vecs[i]) begin
                    if (vecs[i].run == run && vecs[i].cyc == c && vecs[i].drv) begin
                        start       = 1'b1;
                        inverse_req = vecs[i].inv;
                    end
                end
                if (run == 2 && c == 400) r = 1'b0;
                if (run == 2 && c == 402) r = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
